comparator_csr_master: RTL and testbench

Hardware Avalon-MM master that drives the fingerprint comparator's CSR slave port without Nios involvement. It accepts task-configuration commands from the monitor/scheduler logic into a small FIFO and serialises them into CSR writes: core assignment, maxcount, NMR, and pointer start/end. It also services the comparator interrupt by reading the exception, success and fail registers, clearing them, and presenting one result record per comparison.

---
 rtl/comparator_csr_master_if.sv | 21 ++
 rtl/comparator_csr_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_comparator_csr_master.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_csr_master_if.sv
// Avalon-MM CSR bus between comparator_csr_master and the comparator's CSR slave port.
interface comparator_csr_master_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] csr_address;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic              csr_waitrequest;

    modport master (
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata, csr_waitrequest
    );

    modport slave (
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata, csr_waitrequest
    );
endinterface

// File: rtl/comparator_csr_master.sv
// Avalon-MM master that serialises queued task-config commands into comparator CSR writes
// and services the comparator irq. Optional watchdog: COMPARATOR_CSR_MASTER_TIMEOUT_EN.
module comparator_csr_master #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned EXC_OFF        = 0,
    parameter int unsigned SUCC_OFF       = 1,
    parameter int unsigned FAIL_OFF       = 2,
    parameter int unsigned MAXCNT_OFF     = 3,
    parameter int unsigned CAT_OFF        = 4,
    parameter int unsigned NMR_OFF        = 5,
    parameter int unsigned PTR_START_BASE = 'h040,
    parameter int unsigned PTR_END_BASE   = 'h080,
    parameter int unsigned EXC_IRQ_BIT    = 0,
    parameter int unsigned EXC_MM_BIT     = 1,
    parameter int unsigned EXC_TASK_LSB   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [2:0]                      cmd_type,
    input  logic [3:0]                      cmd_task_id,
    input  logic [1:0]                      cmd_logical_core_id,
    input  logic [15:0]                     cmd_data,
    comparator_csr_master_if.master         csr,
    input  logic                            irq,
    output logic                            res_valid,
    output logic [3:0]                      res_task_id,
    output logic                            res_mismatch,
    output logic [15:0]                     res_success,
    output logic [31:0]                     res_fail,
    output logic                            busy,
    output logic                            err
);

    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    generate
        if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0) ||
            (EXC_IRQ_BIT == EXC_MM_BIT) || (TIMEOUT_CYCLES == 0)) begin : g_param_check
            $error("comparator_csr_master: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, CMD_WR, RD_EXC, RD_SUCC, RD_FAIL, CLR_EXC, RESULT
    } state_t;

    typedef struct packed {
        logic [2:0]  ctype;
        logic [3:0]  task_id;
        logic [1:0]  lcore;
        logic [15:0] data;
    } cmd_t;

    state_t            state;
    cmd_t              fifo_mem [CMD_DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        cap_task;
    logic              cap_mm;
    logic [15:0]       cap_succ;
    logic [31:0]       cap_fail;
    logic              timeout_hit;

    assign csr.csr_address   = addr_q;
    assign csr.csr_read      = rd_q;
    assign csr.csr_write     = wr_q;
    assign csr.csr_writedata = wdata_q;

    assign head      = fifo_mem[rd_ptr];
    assign cmd_ready = (count < CNT_W'(CMD_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !irq && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    function automatic logic [ADDR_W-1:0] cmd_addr(input cmd_t c);
        logic [ADDR_W-1:0] tid;
        tid = ADDR_W'(c.task_id);
        case (c.ctype)
            3'd0:    return ADDR_W'(CAT_OFF);
            3'd1:    return ADDR_W'(MAXCNT_OFF);
            3'd2:    return ADDR_W'(NMR_OFF);
            3'd3:    return ADDR_W'(PTR_START_BASE) | tid;
            default: return ADDR_W'(PTR_END_BASE) | tid;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{ctype: cmd_type, task_id: cmd_task_id,
                                   lcore: cmd_logical_core_id, data: cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Each read/clear state raises its own strobe on entry, which yields the one-cycle
    // gap after the previous transfer's completion edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            cap_task     <= '0;
            cap_mm       <= 1'b0;
            cap_succ     <= '0;
            cap_fail     <= '0;
            res_valid    <= 1'b0;
            res_task_id  <= '0;
            res_mismatch <= 1'b0;
            res_success  <= '0;
            res_fail     <= '0;
        end else begin
            res_valid <= 1'b0;
            if (timeout_hit) begin
                rd_q  <= 1'b0;
                wr_q  <= 1'b0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (irq) begin
                            rd_q   <= 1'b1;
                            addr_q <= ADDR_W'(EXC_OFF);
                            state  <= RD_EXC;
                        end else if ((count != '0) && (head.ctype <= 3'd4)) begin
                            wr_q    <= 1'b1;
                            addr_q  <= cmd_addr(head);
                            wdata_q <= {6'b0, head.lcore, 4'b0, head.task_id, head.data};
                            state   <= CMD_WR;
                        end
                    end
                    CMD_WR: begin
                        if (!csr.csr_waitrequest) begin
                            wr_q  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    RD_EXC: begin
                        if (!csr.csr_waitrequest) begin
                            cap_task <= csr.csr_readdata[EXC_TASK_LSB +: 4];
                            cap_mm   <= csr.csr_readdata[EXC_MM_BIT];
                            rd_q     <= 1'b0;
                            state    <= RD_SUCC;
                        end
                    end
                    RD_SUCC: begin
                        if (!rd_q) begin
                            rd_q   <= 1'b1;
                            addr_q <= ADDR_W'(SUCC_OFF);
                        end else if (!csr.csr_waitrequest) begin
                            cap_succ <= csr.csr_readdata[15:0];
                            rd_q     <= 1'b0;
                            state    <= RD_FAIL;
                        end
                    end
                    RD_FAIL: begin
                        if (!rd_q) begin
                            rd_q   <= 1'b1;
                            addr_q <= ADDR_W'(FAIL_OFF);
                        end else if (!csr.csr_waitrequest) begin
                            cap_fail <= csr.csr_readdata;
                            rd_q     <= 1'b0;
                            state    <= CLR_EXC;
                        end
                    end
                    CLR_EXC: begin
                        if (!wr_q) begin
                            wr_q    <= 1'b1;
                            addr_q  <= ADDR_W'(EXC_OFF);
                            wdata_q <= '0;
                        end else if (!csr.csr_waitrequest) begin
                            wr_q         <= 1'b0;
                            res_valid    <= 1'b1;
                            res_task_id  <= cap_task;
                            res_mismatch <= cap_mm;
                            res_success  <= cap_succ;
                            res_fail     <= cap_fail;
                            state        <= RESULT;
                        end
                    end
                    RESULT:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef COMPARATOR_CSR_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    logic            stalled;

    assign stalled     = (rd_q || wr_q) && csr.csr_waitrequest;
    // Fires on the TIMEOUT_CYCLES-th stalled edge, so the strobe is high for exactly that many cycles.
    assign timeout_hit = stalled && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (timeout_hit) begin
            to_cnt <= '0;
            err_q  <= 1'b1;
        end else if (stalled) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_comparator_csr_master.sv
// Randomized self-checking bench for comparator_csr_master: behavioural CSR slave plus
// expected-transfer and expected-result scoreboards built from the command/irq rules.
module tb_comparator_csr_master;

    localparam int unsigned ADDR_W = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_type;
    logic [3:0]  cmd_task_id;
    logic [1:0]  cmd_logical_core_id;
    logic [15:0] cmd_data;
    logic        irq;
    logic        res_valid;
    logic [3:0]  res_task_id;
    logic        res_mismatch;
    logic [15:0] res_success;
    logic [31:0] res_fail;
    logic        busy;
    logic        err;

    comparator_csr_master_if #(.ADDR_W(ADDR_W)) csr_bus ();

    comparator_csr_master #(
        .ADDR_W(ADDR_W),
        .CMD_DEPTH(4),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_task_id(cmd_task_id),
        .cmd_logical_core_id(cmd_logical_core_id),
        .cmd_data(cmd_data),
        .csr(csr_bus.master),
        .irq(irq),
        .res_valid(res_valid),
        .res_task_id(res_task_id),
        .res_mismatch(res_mismatch),
        .res_success(res_success),
        .res_fail(res_fail),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cycles;
    } xfer_t;

    typedef struct {
        logic [3:0]  tid;
        logic        mm;
        logic [15:0] succ;
        logic [31:0] fail;
    } res_t;

    xfer_t got_x[$];
    xfer_t exp_x[$];
    res_t  got_r[$];
    res_t  exp_r[$];
    int    x_rd = 0;
    int    r_rd = 0;

    int n_cmp = 0;
    int n_err = 0;

    // Slave-side register model and stall control
    logic [31:0] exc_v, succ_v, fail_v;
    bit          hold_wait = 1'b0;
    int          fixed_stall = -1;
    int          irq_raise_n = 0;
    int          irq_clear_n = 0;
    int          stab_bad = 0;
    int          gap_bad = 0;

    assign irq = (irq_raise_n != irq_clear_n);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_wdata(input int lc, input int tid, input int d);
        return 32'(lc * 32'h0100_0000 + tid * 32'h0001_0000 + d);
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int ty, input int tid);
        case (ty)
            0:       return ADDR_W'(4);
            1:       return ADDR_W'(3);
            2:       return ADDR_W'(5);
            3:       return ADDR_W'(64 + tid);
            default: return ADDR_W'(128 + tid);
        endcase
    endfunction

    // Behavioural CSR slave: one transfer per strobe, random or directed stall length
    bit                in_xfer = 1'b0;
    bit                just_done = 1'b0;
    int                stall_left = 0;
    int                cyc = 0;
    bit                s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_data;

    always @(negedge clk) begin
        logic act;
        act = csr_bus.csr_read | csr_bus.csr_write;
        if (just_done && act) gap_bad++;
        just_done = 1'b0;
        if (!act) begin
            in_xfer = 1'b0;
            csr_bus.csr_waitrequest = 1'b0;
            csr_bus.csr_readdata = $urandom;
        end else begin
            if (!in_xfer) begin
                in_xfer = 1'b1;
                cyc = 0;
                s_wr = csr_bus.csr_write;
                s_addr = csr_bus.csr_address;
                s_data = csr_bus.csr_writedata;
                stall_left = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, 3));
            end else if ((csr_bus.csr_address !== s_addr) || (csr_bus.csr_write !== s_wr) ||
                         (s_wr && (csr_bus.csr_writedata !== s_data))) begin
                stab_bad++;
            end
            cyc++;
            if (hold_wait || stall_left > 0) begin
                csr_bus.csr_waitrequest = 1'b1;
                csr_bus.csr_readdata = $urandom;
                if (stall_left > 0) stall_left--;
            end else begin
                csr_bus.csr_waitrequest = 1'b0;
                case (int'(s_addr))
                    0:       csr_bus.csr_readdata = exc_v;
                    1:       csr_bus.csr_readdata = succ_v;
                    2:       csr_bus.csr_readdata = fail_v;
                    default: csr_bus.csr_readdata = $urandom;
                endcase
                got_x.push_back('{s_wr, s_addr, s_wr ? s_data : 32'h0, cyc});
                if (s_wr && s_addr == '0) irq_clear_n = irq_raise_n;
                in_xfer = 1'b0;
                just_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (res_valid) got_r.push_back('{res_task_id, res_mismatch, res_success, res_fail});
    end

    task automatic drive_cmd(input int ty, input int tid, input int lc, input int d);
        cmd_valid = 1'b1;
        cmd_type = 3'(ty);
        cmd_task_id = 4'(tid);
        cmd_logical_core_id = 2'(lc);
        cmd_data = 16'(d);
        if (ty < 5) exp_x.push_back('{1'b1, exp_addr(ty, tid), exp_wdata(lc, tid, d), 0});
    endtask

    task automatic push_cmd(input int ty, input int tid, input int lc, input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 600);
        check("push_ready", 64'(cmd_ready), 64'(1));
        if (cmd_ready) begin
            drive_cmd(ty, tid, lc, d);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic expect_irq(input logic [31:0] exc, input logic [31:0] succ, input logic [31:0] fail);
        exp_x.push_back('{1'b0, ADDR_W'(0), 32'h0, 0});
        exp_x.push_back('{1'b0, ADDR_W'(1), 32'h0, 0});
        exp_x.push_back('{1'b0, ADDR_W'(2), 32'h0, 0});
        exp_x.push_back('{1'b1, ADDR_W'(0), 32'h0, 0});
        exp_r.push_back('{4'((exc >> 4) & 32'hF), 1'((exc >> 1) & 32'h1), 16'(succ), fail});
    endtask

    task automatic raise_irq(input logic [31:0] exc, input logic [31:0] succ, input logic [31:0] fail);
        exc_v = exc;
        succ_v = succ;
        fail_v = fail;
        irq_raise_n++;
        expect_irq(exc, succ, fail);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        repeat (3) @(negedge clk);
        n = 0;
        while ((busy || irq) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(busy | irq), 64'(0));
    endtask

    task automatic score(input string tag);
        int ng, nr;
        ng = got_x.size() - x_rd;
        check({tag, "_nxfer"}, 64'(ng), 64'(exp_x.size()));
        for (int i = 0; i < exp_x.size() && i < ng; i++) begin
            check({tag, "_wr"},   64'(got_x[x_rd + i].wr),   64'(exp_x[i].wr));
            check({tag, "_addr"}, 64'(got_x[x_rd + i].addr), 64'(exp_x[i].addr));
            check({tag, "_data"}, 64'(got_x[x_rd + i].data), 64'(exp_x[i].data));
        end
        x_rd = got_x.size();
        exp_x.delete();
        nr = got_r.size() - r_rd;
        check({tag, "_nres"}, 64'(nr), 64'(exp_r.size()));
        for (int i = 0; i < exp_r.size() && i < nr; i++) begin
            check({tag, "_rtask"}, 64'(got_r[r_rd + i].tid),  64'(exp_r[i].tid));
            check({tag, "_rmm"},   64'(got_r[r_rd + i].mm),   64'(exp_r[i].mm));
            check({tag, "_rsucc"}, 64'(got_r[r_rd + i].succ), 64'(exp_r[i].succ));
            check({tag, "_rfail"}, 64'(got_r[r_rd + i].fail), 64'(exp_r[i].fail));
        end
        r_rd = got_r.size();
        exp_r.delete();
        check({tag, "_stable"}, 64'(stab_bad), 64'(0));
        check({tag, "_gap"},    64'(gap_bad),  64'(0));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, nb;
        logic [31:0] e, s, f;
        cmd_valid = 1'b0;
        cmd_type = '0;
        cmd_task_id = '0;
        cmd_logical_core_id = '0;
        cmd_data = '0;
        exc_v = '0;
        succ_v = '0;
        fail_v = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_write",  64'(csr_bus.csr_write), 64'(0));
        check("rst_read",   64'(csr_bus.csr_read),  64'(0));
        check("rst_ready",  64'(cmd_ready),         64'(1));
        check("rst_resv",   64'(res_valid),         64'(0));
        check("rst_busy",   64'(busy),              64'(0));
        check("rst_err",    64'(err),               64'(0));
        check("rst_rtask",  64'(res_task_id),       64'(0));
        reset = 1'b0;

        // CAT write with a 3-cycle stall
        fixed_stall = 3;
        push_cmd(0, 3, 1, 5);
        wait_idle("cat");
        if (got_x.size() > x_rd) check("cat_cycles", 64'(got_x[x_rd].cycles), 64'(4));
        else check("cat_seen", 64'(got_x.size() - x_rd), 64'(1));
        check("cat_wdata_const", 64'(exp_x.size() > 0 ? exp_x[0].data : 32'h0), 64'(32'h0103_0005));
        score("cat");
        fixed_stall = -1;

        // Fill: one command in flight plus CMD_DEPTH queued, then the next is held off
        hold_wait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fill_ready", 64'(cmd_ready), 64'(1));
            drive_cmd(1, k, k & 3, int'($urandom_range(0, 16'hFFFF)));
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
        @(negedge clk);
        check("full_ready", 64'(cmd_ready), 64'(0));
        check("full_busy",  64'(busy),      64'(1));
        hold_wait = 1'b0;
        push_cmd(1, 15, 2, 16'hBEEF);
        wait_idle("fill");
        score("fill");

        // Directed irq service
        @(negedge clk);
        raise_irq(32'h0000_0073, 32'h0000_0008, 32'hFFFF_FFFF);
        wait_idle("irq");
        score("irq");
        check("irq_hold_task", 64'(res_task_id),  64'(7));
        check("irq_hold_mm",   64'(res_mismatch), 64'(1));
        check("irq_hold_succ", 64'(res_success),  64'(16'h0008));
        check("irq_hold_fail", 64'(res_fail),     64'(32'hFFFF_FFFF));
        check("irq_resv_low",  64'(res_valid),    64'(0));

        // irq and command offered in the same IDLE cycle
        @(negedge clk);
        raise_irq(32'h0000_0052, 32'h0000_1234, 32'h5555_AAAA);
        drive_cmd(2, 6, 3, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_idle("prio");
        score("prio");

        // Randomised mix of command batches and irq services
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            e = $urandom;
            s = $urandom;
            f = $urandom;
            if (kind <= 1) begin
                nb = int'($urandom_range(1, 7));
                for (int j = 0; j < nb; j++) begin
                    push_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end else if (kind == 2) begin
                @(negedge clk);
                raise_irq(e, s, f);
            end else begin
                @(negedge clk);
                raise_irq(e, s, f);
                drive_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)));
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end
            wait_idle("rnd");
            score("rnd");
        end

        // Pointer address, then reset while the slave stalls with a command still queued
        hold_wait = 1'b1;
        push_cmd(4, 9, 2, 16'h1234);
        push_cmd(3, 1, 0, 16'h0042);
        exp_x.delete();
        @(negedge clk);
        check("ptr_write", 64'(csr_bus.csr_write),     64'(1));
        check("ptr_addr",  64'(csr_bus.csr_address),   64'(ADDR_W'('h089)));
        check("ptr_data",  64'(csr_bus.csr_writedata), 64'(exp_wdata(2, 9, 16'h1234)));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_write", 64'(csr_bus.csr_write), 64'(0));
        check("mid_rst_read",  64'(csr_bus.csr_read),  64'(0));
        check("mid_rst_busy",  64'(busy),              64'(0));
        check("mid_rst_ready", 64'(cmd_ready),         64'(1));
        reset = 1'b0;
        hold_wait = 1'b0;
        repeat (20) @(negedge clk);
        score("post_rst");

`ifdef COMPARATOR_CSR_MASTER_TIMEOUT_EN
        begin
            int n_hi, n;
            hold_wait = 1'b1;
            push_cmd(0, 1, 0, 1);
            exp_x.delete();
            n_hi = 0;
            n = 0;
            while (n < 700) begin
                @(negedge clk);
                n++;
                if (csr_bus.csr_write) n_hi++;
                else if (n_hi > 0) break;
            end
            check("to_cycles", 64'(n_hi), 64'(256));
            check("to_err",    64'(err),  64'(1));
            check("to_busy",   64'(busy), 64'(0));
            hold_wait = 1'b0;
            repeat (5) @(negedge clk);
            check("to_err_sticky", 64'(err), 64'(1));
            score("to");
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("to_err_clr", 64'(err), 64'(0));
        end
`else
        check("err_tied", 64'(err), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
